// File: rtl/sqrt_iter_if.sv
// Valid/ready bundle for the iterative square-root unit:
// radicand request channel plus root response channel.
interface sqrt_iter_if #(
  parameter int IN_W  = 31,
  parameter int OUT_W = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  e;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] f;

  modport master (
    output in_valid,
    output e,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  f
  );

  modport slave (
    input  in_valid,
    input  e,
    input  out_ready,
    output in_ready,
    output out_valid,
    output f
  );
endinterface

// File: rtl/sqrt_iter.sv
// Restoring digit-by-digit square root, one result bit per clock,
// with optional round-to-nearest and saturation on overflow.
module sqrt_iter #(
  parameter int IN_W      = 31,
  parameter int OUT_W     = 17,
  parameter int PRE_SHIFT = 2,
  parameter int ROUND     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  sqrt_iter_if.slave io,
  output logic       busy
);

  localparam int W2 = 2 * OUT_W;
  localparam int RW = OUT_W + 2;
  localparam int CW = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W2-1:0]    rad_q, rad_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [OUT_W-1:0] f_q, f_d;
  logic             ov_q, ov_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [W2-1:0]    rad_in;
  logic [RW-1:0]    rem_sh;
  logic [RW-1:0]    trial;
  logic [RW-1:0]    rem_nx;
  logic [OUT_W-1:0] root_nx;
  logic [OUT_W-1:0] f_fin;
  logic             take;
  logic             up;
  logic             last;

  assign rad_in = W2'(io.e) << PRE_SHIFT;

  // Top remainder bits are provably zero, so the shift drops nothing.
  assign rem_sh  = {rem_q[OUT_W-1:0], rad_q[W2-1 -: 2]};
  assign trial   = {root_q, 2'b01};
  assign take    = rem_sh >= trial;
  assign rem_nx  = take ? rem_sh - trial : rem_sh;
  assign root_nx = {root_q[OUT_W-2:0], take};
  assign up      = (ROUND != 0) && (rem_nx > {2'b00, root_nx});
  assign last    = iter_q == CW'(OUT_W - 1);

  always_comb begin
    f_fin = root_nx;
    if (up && !(&root_nx)) f_fin = root_nx + OUT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    iter_d  = iter_q;
    f_d     = f_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_ready_q && io.in_valid) begin
          state_d = CALC;
          rad_d   = rad_in;
          rem_d   = '0;
          root_d  = '0;
          iter_d  = '0;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        iter_d = iter_q + CW'(1);
        if (last) begin
          state_d = DONE;
          f_d     = f_fin;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    busy_d     = state_d == CALC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      f_q        <= '0;
      ov_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      f_q        <= f_d;
      ov_q       <= ov_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = ov_q;
  assign io.f         = f_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: default and 4-bit configs,
// both rounding modes, backpressure, reset abort, random stream.
module tb_sqrt_iter;

  logic clk;
  logic rst_n;
  logic b0, b1, b2, b3;

  int n_cmp = 0;
  int n_bad = 0;
  int acc0  = 0;
  int out0  = 0;

  longint q0[$];
  longint q1[$];
  longint q2[$];
  longint q3[$];

  sqrt_iter_if #(.IN_W(31), .OUT_W(17)) i0 ();
  sqrt_iter_if #(.IN_W(31), .OUT_W(17)) i1 ();
  sqrt_iter_if #(.IN_W(8),  .OUT_W(4))  i2 ();
  sqrt_iter_if #(.IN_W(8),  .OUT_W(4))  i3 ();

  sqrt_iter #(.IN_W(31), .OUT_W(17), .PRE_SHIFT(2), .ROUND(0))
    u0 (.clk(clk), .rst_n(rst_n), .io(i0), .busy(b0));
  sqrt_iter #(.IN_W(31), .OUT_W(17), .PRE_SHIFT(2), .ROUND(1))
    u1 (.clk(clk), .rst_n(rst_n), .io(i1), .busy(b1));
  sqrt_iter #(.IN_W(8), .OUT_W(4), .PRE_SHIFT(0), .ROUND(1))
    u2 (.clk(clk), .rst_n(rst_n), .io(i2), .busy(b2));
  sqrt_iter #(.IN_W(8), .OUT_W(4), .PRE_SHIFT(0), .ROUND(0))
    u3 (.clk(clk), .rst_n(rst_n), .io(i3), .busy(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, longint got, longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: float sqrt, then integer correction.
  function automatic longint exp_f(longint e, int ps, int ow, bit rnd);
    longint r_ad, r, rem, mx;
    r_ad = e << ps;
    r = longint'($floor($sqrt(real'(r_ad))));
    while (r * r > r_ad) r--;
    while ((r + 1) * (r + 1) <= r_ad) r++;
    rem = r_ad - r * r;
    if (rnd && rem > r) r++;
    mx = (longint'(1) << ow) - 1;
    if (r > mx) r = mx;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
    end else begin
      if (i0.in_valid && i0.in_ready) begin
        q0.push_back(exp_f(longint'(i0.e), 2, 17, 1'b0));
        acc0++;
      end
      if (i1.in_valid && i1.in_ready)
        q1.push_back(exp_f(longint'(i1.e), 2, 17, 1'b1));
      if (i2.in_valid && i2.in_ready)
        q2.push_back(exp_f(longint'(i2.e), 0, 4, 1'b1));
      if (i3.in_valid && i3.in_ready)
        q3.push_back(exp_f(longint'(i3.e), 0, 4, 1'b0));
      if (i0.out_valid && i0.out_ready) begin
        out0++;
        if (q0.size() == 0) chk("u0 spurious out", 1, 0);
        else chk("u0 f", longint'(i0.f), q0.pop_front());
      end
      if (i1.out_valid && i1.out_ready) begin
        if (q1.size() == 0) chk("u1 spurious out", 1, 0);
        else chk("u1 f", longint'(i1.f), q1.pop_front());
      end
      if (i2.out_valid && i2.out_ready) begin
        if (q2.size() == 0) chk("u2 spurious out", 1, 0);
        else chk("u2 f", longint'(i2.f), q2.pop_front());
      end
      if (i3.out_valid && i3.out_ready) begin
        if (q3.size() == 0) chk("u3 spurious out", 1, 0);
        else chk("u3 f", longint'(i3.f), q3.pop_front());
      end
    end
  end

  function automatic bit rdy(int u);
    case (u)
      0: return i0.in_ready;
      1: return i1.in_ready;
      2: return i2.in_ready;
      default: return i3.in_ready;
    endcase
  endfunction

  function automatic int qsize(int u);
    case (u)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic set_in(int u, bit v, longint val);
    case (u)
      0: begin i0.in_valid = v; i0.e = val[30:0]; end
      1: begin i1.in_valid = v; i1.e = val[30:0]; end
      2: begin i2.in_valid = v; i2.e = val[7:0]; end
      default: begin i3.in_valid = v; i3.e = val[7:0]; end
    endcase
  endtask

  // Present val; returns #1 after the accept edge.
  task automatic send(int u, longint val);
    int n = 0;
    bit ok = 1'b0;
    set_in(u, 1'b1, val);
    while (!ok && n < 200) begin
      @(negedge clk);
      if (rdy(u)) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    set_in(u, 1'b0, val);
    if (!ok) chk("send timeout", 0, 1);
  endtask

  task automatic wait_done(int u);
    int n = 0;
    while (qsize(u) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (qsize(u) != 0) chk("result timeout", qsize(u), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit drv_done;
    logic [16:0] f_hold;
    rst_n = 1'b0;
    set_in(0, 1'b0, 0); set_in(1, 1'b0, 0);
    set_in(2, 1'b0, 0); set_in(3, 1'b0, 0);
    i0.out_ready = 1'b0;
    i1.out_ready = 1'b1;
    i2.out_ready = 1'b1;
    i3.out_ready = 1'b1;
    #23;
    chk("rst f", longint'(i0.f), 0);
    chk("rst out_valid", longint'(i0.out_valid), 0);
    chk("rst busy", longint'(b0), 0);
    chk("rst in_ready", longint'(i0.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle in_ready", longint'(i0.in_ready), 1);

    // latency, CALC-time input noise, then backpressure
    send(0, 16777216);
    chk("calc busy", longint'(b0), 1);
    chk("calc in_ready", longint'(i0.in_ready), 0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (i0.out_valid) begin
        lat = k;
        break;
      end
      i0.in_valid = 1'($urandom);
      i0.e = 31'($urandom);
    end
    i0.in_valid = 1'b0;
    chk("latency", lat, 17);
    chk("f 1.0", longint'(i0.f), 8192);
    f_hold = i0.f;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp hold", longint'({i0.out_valid, i0.in_ready, i0.f}),
          longint'({1'b1, 1'b0, f_hold}));
    end
    i0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    i0.out_ready = 1'b0;
    chk("bp release out_valid", longint'(i0.out_valid), 0);
    chk("bp release in_ready", longint'(i0.in_ready), 1);
    chk("f held after DONE", longint'(i0.f), 8192);

    i0.out_ready = 1'b1;
    send(0, 0);
    wait_done(0);
    chk("e=0", longint'(i0.f), 0);
    send(0, 2);
    wait_done(0);
    chk("e=2 trunc", longint'(i0.f), 2);

    send(1, 2147483647);
    wait_done(1);
    chk("e=max round", longint'(i1.f), 92682);
    send(1, 2);
    wait_done(1);
    chk("e=2 round", longint'(i1.f), 3);
    send(2, 255);
    wait_done(2);
    chk("sat round", longint'(i2.f), 15);
    send(3, 255);
    wait_done(3);
    chk("small 255 trunc", longint'(i3.f), 15);
    send(3, 224);
    wait_done(3);
    chk("small 224 trunc", longint'(i3.f), 14);

    // abort mid-iteration
    send(0, 16777216);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", longint'(i0.out_valid), 0);
    chk("abort f", longint'(i0.f), 0);
    chk("abort busy", longint'(b0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 67108864);
    wait_done(0);
    chk("after abort", longint'(i0.f), 16384);

    // random stream with gaps on both sides
    acc0 = 0;
    out0 = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1500; n++) begin
          longint v;
          v = longint'($urandom & 32'h7fff_ffff);
          if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 30);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(0, v);
        end
        drv_done = 1'b1;
      end
      begin
        int cyc = 0;
        while ((!drv_done || q0.size() != 0) && cyc < 90000) begin
          @(posedge clk);
          #1;
          i0.out_ready = 1'($urandom_range(0, 1));
          cyc++;
        end
      end
    join
    i0.out_ready = 1'b1;
    chk("stream drained", q0.size(), 0);
    chk("stream accepted", acc0, 1500);
    chk("stream count", out0, acc0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
